// File: rtl/spi_target_ctrl.sv
// spi_target_ctrl: SPI target-side controller. It sits behind the SPI input
// conditioner and drives a single-cycle synchronous memory port.
//   Frame (MSB first): ADDR_W address bits, 1 R/W bit (1 = read), then
//   DATA_W-bit words. With BURST=1 the words continue at address+1, +2, ...
//   (wrapping) for as long as cs_n stays low.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   cs_n, mosi            conditioned chip select (active low) and data in
//   sclk_pos, sclk_neg    one-clk pulses on SCLK rising / falling edges
//   miso, miso_oe         serial data out (tx_sr MSB) and its output enable
//   mem_addr, mem_wdata   memory address and write data
//   mem_we, mem_re        one-clk write / read strobes
//   mem_rdata             read data, valid the clk after mem_re
//   busy                  FSM not idle
//   frame_err             one-clk pulse when cs_n rises mid-word
module spi_target_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int BURST  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RW, S_DATA, S_DONE} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rx_sr, tx_sr, rx_next;
  logic                rw_q, re_d;
  logic                do_addr, do_rw, do_data, word_done, abort;

  assign rx_next  = (rx_sr << 1) | DATA_W'(mosi);
  assign mem_addr = addr_q;
  assign miso     = tx_sr[DATA_W-1];
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    do_addr   = 1'b0;
    do_rw     = 1'b0;
    do_data   = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    if (cs_n) begin
      // cs_n release wins over any coincident SCLK edge
      state_d = S_IDLE;
      abort   = (state inside {S_ADDR, S_RW, S_DATA}) && (cnt != '0);
    end else begin
      unique case (state)
        S_IDLE: begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
        S_ADDR: if (sclk_pos) begin
          do_addr = 1'b1;
          cnt_d   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(ADDR_W - 1)) state_d = S_RW;
        end
        S_RW: if (sclk_pos) begin
          do_rw   = 1'b1;
          cnt_d   = '0;
          state_d = S_DATA;
        end
        S_DATA: if (sclk_pos) begin
          do_data = 1'b1;
          cnt_d   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            word_done = 1'b1;
            if (BURST != 0) cnt_d = '0;
            else            state_d = S_DONE;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rw_q      <= 1'b0;
      re_d      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      frame_err <= abort;
      re_d      <= mem_re;
      if (do_addr) addr_q <= (addr_q << 1) | ADDR_W'(mosi);
      if (do_rw) begin
        rw_q <= mosi;
        if (mosi) begin
          mem_re  <= 1'b1;
          miso_oe <= 1'b1;
        end
      end
      if (do_data) rx_sr <= rx_next;
      if (word_done) begin
        if (!rw_q) begin
          mem_we    <= 1'b1;
          mem_wdata <= rx_next;
        end else if (BURST != 0) begin
          mem_re <= 1'b1;
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      // a burst write keeps the address stable during the strobe, then steps
      if (mem_we && (BURST != 0)) addr_q <= addr_q + ADDR_W'(1);
      if (cs_n) miso_oe <= 1'b0;
      // the falling edge right after a word boundary (cnt==0) would discard
      // the freshly loaded MSB before the controller samples it, so skip it
      if (re_d)
        tx_sr <= mem_rdata;
      else if (sclk_neg && !cs_n && state == S_DATA && rw_q && cnt != '0)
        tx_sr <= tx_sr << 1;
    end
  end

endmodule

// File: tb/tb_spi_target_ctrl.sv
module tb_spi_target_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sclk_pos, sclk_neg, mosi;
  logic cs_a, cs_b, cs_c;

  logic       miso_a, oe_a, we_a, re_a, busy_a, ferr_a;
  logic [6:0] addr_a;
  logic [7:0] wdata_a;
  logic [7:0] rdata_a = '0;

  logic        miso_b, oe_b, we_b, re_b, busy_b, ferr_b;
  logic [3:0]  addr_b;
  logic [15:0] wdata_b;
  logic [15:0] rdata_b = '0;

  logic       miso_c, oe_c, we_c, re_c, busy_c, ferr_c;
  logic [6:0] addr_c;
  logic [7:0] wdata_c;
  logic [7:0] rdata_c = '0;

  int vectors = 0;
  int miscompares = 0;

  spi_target_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_a), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .mosi(mosi), .miso(miso_a), .miso_oe(oe_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_we(we_a), .mem_re(re_a), .mem_rdata(rdata_a), .busy(busy_a), .frame_err(ferr_a)
  );

  spi_target_ctrl #(.ADDR_W(4), .DATA_W(16), .BURST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_b), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .mosi(mosi), .miso(miso_b), .miso_oe(oe_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_we(we_b), .mem_re(re_b), .mem_rdata(rdata_b), .busy(busy_b), .frame_err(ferr_b)
  );

  spi_target_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(0)) u_c (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_c), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .mosi(mosi), .miso(miso_c), .miso_oe(oe_c), .mem_addr(addr_c), .mem_wdata(wdata_c),
    .mem_we(we_c), .mem_re(re_c), .mem_rdata(rdata_c), .busy(busy_c), .frame_err(ferr_c)
  );

  // memory model for instance A: registered read, 0x5C at address 3
  always @(posedge clk)
    if (re_a) rdata_a <= (addr_a == 7'h03) ? 8'h5C : {1'b1, addr_a};

  int we_n_a, re_n_a, ferr_n_a, oe_n_a;
  logic [6:0] we_addr_a, re_addr_a;
  logic [7:0] we_data_a;
  int we_n_b, re_n_b, ferr_n_b, oe_n_b, miso_n_b;
  logic [3:0]  b_addr [4];
  logic [15:0] b_data [4];
  int we_n_c, re_n_c, ferr_n_c, oe_n_c, miso_n_c;
  logic [6:0] we_addr_c;
  logic [7:0] we_data_c;

  always @(negedge clk) begin
    if (we_a) begin we_n_a++; we_addr_a = addr_a; we_data_a = wdata_a; end
    if (re_a) begin re_n_a++; re_addr_a = addr_a; end
    if (ferr_a) ferr_n_a++;
    if (oe_a) oe_n_a++;
    if (we_b) begin b_addr[we_n_b % 4] = addr_b; b_data[we_n_b % 4] = wdata_b; we_n_b++; end
    if (re_b) re_n_b++;
    if (ferr_b) ferr_n_b++;
    if (oe_b) oe_n_b++;
    if (miso_b) miso_n_b++;
    if (we_c) begin we_n_c++; we_addr_c = addr_c; we_data_c = wdata_c; end
    if (re_c) re_n_c++;
    if (ferr_c) ferr_n_c++;
    if (oe_c) oe_n_c++;
    if (miso_c) miso_n_c++;
  end

  // one SCLK period: rising pulse, >=4 clk gap, falling pulse, gap
  task automatic drive_bit(input logic b, output logic sampled);
    @(posedge clk); #1; mosi = b; sclk_pos = 1'b1;
    @(negedge clk); sampled = miso_a;
    @(posedge clk); #1; sclk_pos = 1'b0;
    repeat (3) @(posedge clk);
    #1; sclk_neg = 1'b1;
    @(posedge clk); #1; sclk_neg = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i], s);
  endtask

  task automatic cs_drive(input int which, input logic level);
    @(posedge clk); #1;
    case (which)
      0: cs_a = level;
      1: cs_b = level;
      default: cs_c = level;
    endcase
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cs_a = 1'b1; cs_b = 1'b1; cs_c = 1'b1;
    sclk_pos = 1'b0; sclk_neg = 1'b0; mosi = 1'b0;
    #12;
    vectors++; if (miso_a !== 1'b0)     begin miscompares++; $display("FAIL rst_miso got %b exp 0", miso_a); end
    vectors++; if (oe_a !== 1'b0)       begin miscompares++; $display("FAIL rst_oe got %b exp 0", oe_a); end
    vectors++; if (addr_a !== 7'h00)    begin miscompares++; $display("FAIL rst_addr got %h exp 00", addr_a); end
    vectors++; if (wdata_a !== 8'h00)   begin miscompares++; $display("FAIL rst_wdata got %h exp 00", wdata_a); end
    vectors++; if (we_a !== 1'b0)       begin miscompares++; $display("FAIL rst_we got %b exp 0", we_a); end
    vectors++; if (re_a !== 1'b0)       begin miscompares++; $display("FAIL rst_re got %b exp 0", re_a); end
    vectors++; if (busy_a !== 1'b0)     begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy_a); end
    vectors++; if (ferr_a !== 1'b0)     begin miscompares++; $display("FAIL rst_ferr got %b exp 0", ferr_a); end
    vectors++; if ({busy_b, busy_c} !== 2'b00) begin miscompares++; $display("FAIL rst_busy_bc got %b exp 00", {busy_b, busy_c}); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write;
    int w0, f0, o0;
    w0 = we_n_a; f0 = ferr_n_a; o0 = oe_n_a;
    cs_drive(0, 1'b0);
    vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL wr_busy got %b exp 1", busy_a); end
    send(32'h15, 7); send(32'h0, 1); send(32'hA7, 8);
    cs_drive(0, 1'b1);
    vectors++; if (we_n_a - w0 !== 1) begin miscompares++; $display("FAIL wr_count got %0d exp 1", we_n_a - w0); end
    vectors++; if (we_addr_a !== 7'h15) begin miscompares++; $display("FAIL wr_addr got %h exp 15", we_addr_a); end
    vectors++; if (we_data_a !== 8'hA7) begin miscompares++; $display("FAIL wr_data got %h exp a7", we_data_a); end
    vectors++; if (oe_n_a - o0 !== 0) begin miscompares++; $display("FAIL wr_oe cycles got %0d exp 0", oe_n_a - o0); end
    vectors++; if (ferr_n_a - f0 !== 0) begin miscompares++; $display("FAIL wr_ferr got %0d exp 0", ferr_n_a - f0); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL wr_idle got %b exp 0", busy_a); end
  endtask

  task automatic test_read;
    int r0;
    logic [7:0] got;
    logic s;
    r0 = re_n_a;
    cs_drive(0, 1'b0);
    send(32'h03, 7); send(32'h1, 1);
    vectors++; if (re_n_a - r0 !== 1) begin miscompares++; $display("FAIL rd_re_count got %0d exp 1", re_n_a - r0); end
    vectors++; if (re_addr_a !== 7'h03) begin miscompares++; $display("FAIL rd_addr got %h exp 03", re_addr_a); end
    vectors++; if (oe_a !== 1'b1) begin miscompares++; $display("FAIL rd_oe_on got %b exp 1", oe_a); end
    for (int i = 7; i >= 0; i--) begin
      drive_bit(1'b0, s);
      got[i] = s;
    end
    vectors++; if (got !== 8'h5C) begin miscompares++; $display("FAIL rd_miso_bits got %h exp 5c", got); end
    vectors++; if (re_addr_a !== 7'h04) begin miscompares++; $display("FAIL rd_prefetch_addr got %h exp 04", re_addr_a); end
    vectors++; if (oe_a !== 1'b1) begin miscompares++; $display("FAIL rd_oe_hold got %b exp 1", oe_a); end
    cs_drive(0, 1'b1);
    vectors++; if (oe_a !== 1'b0) begin miscompares++; $display("FAIL rd_oe_off got %b exp 0", oe_a); end
  endtask

  task automatic test_burst_wrap;
    int w0, o0, r0, m0;
    w0 = we_n_b; o0 = oe_n_b; r0 = re_n_b; m0 = miso_n_b;
    cs_drive(1, 1'b0);
    send(32'hF, 4); send(32'h0, 1);
    send(32'h1234, 16); send(32'hBEEF, 16); send(32'h0001, 16);
    cs_drive(1, 1'b1);
    vectors++; if (we_n_b - w0 !== 3) begin miscompares++; $display("FAIL bw_count got %0d exp 3", we_n_b - w0); end
    vectors++; if (b_addr[w0 % 4] !== 4'hF) begin miscompares++; $display("FAIL bw_addr0 got %h exp f", b_addr[w0 % 4]); end
    vectors++; if (b_data[w0 % 4] !== 16'h1234) begin miscompares++; $display("FAIL bw_data0 got %h exp 1234", b_data[w0 % 4]); end
    vectors++; if (b_addr[(w0 + 1) % 4] !== 4'h0) begin miscompares++; $display("FAIL bw_addr1 got %h exp 0", b_addr[(w0 + 1) % 4]); end
    vectors++; if (b_data[(w0 + 1) % 4] !== 16'hBEEF) begin miscompares++; $display("FAIL bw_data1 got %h exp beef", b_data[(w0 + 1) % 4]); end
    vectors++; if (b_addr[(w0 + 2) % 4] !== 4'h1) begin miscompares++; $display("FAIL bw_addr2 got %h exp 1", b_addr[(w0 + 2) % 4]); end
    vectors++; if (b_data[(w0 + 2) % 4] !== 16'h0001) begin miscompares++; $display("FAIL bw_data2 got %h exp 0001", b_data[(w0 + 2) % 4]); end
    vectors++; if ((oe_n_b - o0) + (re_n_b - r0) + (miso_n_b - m0) + ferr_n_b !== 0) begin
      miscompares++; $display("FAIL bw_quiet oe/re/miso/ferr cycles got %0d exp 0", (oe_n_b - o0) + (re_n_b - r0) + (miso_n_b - m0) + ferr_n_b);
    end
  endtask

  task automatic test_no_burst;
    int w0, f0;
    w0 = we_n_c; f0 = ferr_n_c;
    cs_drive(2, 1'b0);
    send(32'h10, 7); send(32'h0, 1); send(32'h55, 8); send(32'hFF, 8);
    vectors++; if (busy_c !== 1'b1) begin miscompares++; $display("FAIL nb_done_busy got %b exp 1", busy_c); end
    cs_drive(2, 1'b1);
    vectors++; if (we_n_c - w0 !== 1) begin miscompares++; $display("FAIL nb_count got %0d exp 1", we_n_c - w0); end
    vectors++; if (we_addr_c !== 7'h10) begin miscompares++; $display("FAIL nb_addr got %h exp 10", we_addr_c); end
    vectors++; if (we_data_c !== 8'h55) begin miscompares++; $display("FAIL nb_data got %h exp 55", we_data_c); end
    vectors++; if (ferr_n_c - f0 !== 0) begin miscompares++; $display("FAIL nb_ferr got %0d exp 0", ferr_n_c - f0); end
    vectors++; if (oe_n_c + re_n_c + miso_n_c + busy_c !== 0) begin
      miscompares++; $display("FAIL nb_quiet oe/re/miso/busy got %0d exp 0", oe_n_c + re_n_c + miso_n_c + busy_c);
    end
  endtask

  task automatic test_abort;
    int w0, f0;
    w0 = we_n_a; f0 = ferr_n_a;
    cs_drive(0, 1'b0);
    send(32'h22, 7); send(32'h0, 1); send(32'h5, 3);
    cs_drive(0, 1'b1);
    vectors++; if (ferr_n_a - f0 !== 1) begin miscompares++; $display("FAIL ab_ferr got %0d exp 1", ferr_n_a - f0); end
    vectors++; if (we_n_a - w0 !== 0) begin miscompares++; $display("FAIL ab_no_write got %0d exp 0", we_n_a - w0); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL ab_idle got %b exp 0", busy_a); end
    cs_drive(0, 1'b0);
    send(32'h40, 7); send(32'h0, 1); send(32'h3C, 8);
    cs_drive(0, 1'b1);
    vectors++; if (we_n_a - w0 !== 1) begin miscompares++; $display("FAIL ab_next_count got %0d exp 1", we_n_a - w0); end
    vectors++; if (we_addr_a !== 7'h40) begin miscompares++; $display("FAIL ab_next_addr got %h exp 40", we_addr_a); end
    vectors++; if (we_data_a !== 8'h3C) begin miscompares++; $display("FAIL ab_next_data got %h exp 3c", we_data_a); end
    vectors++; if (ferr_n_a - f0 !== 1) begin miscompares++; $display("FAIL ab_next_ferr got %0d exp 1", ferr_n_a - f0); end
  endtask

  task automatic test_reset_mid_read;
    int w0;
    cs_drive(0, 1'b0);
    send(32'h05, 7);
    @(posedge clk); #1; mosi = 1'b1; sclk_pos = 1'b1;
    @(posedge clk); #1; sclk_pos = 1'b0;
    vectors++; if (re_a !== 1'b1) begin miscompares++; $display("FAIL mr_re_pre got %b exp 1", re_a); end
    vectors++; if (oe_a !== 1'b1) begin miscompares++; $display("FAIL mr_oe_pre got %b exp 1", oe_a); end
    #1; rst_n = 1'b0;
    #1;
    vectors++; if (oe_a !== 1'b0) begin miscompares++; $display("FAIL mr_oe got %b exp 0", oe_a); end
    vectors++; if (re_a !== 1'b0) begin miscompares++; $display("FAIL mr_re got %b exp 0", re_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL mr_busy got %b exp 0", busy_a); end
    cs_a = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    w0 = we_n_a;
    cs_drive(0, 1'b0);
    send(32'h0A, 7); send(32'h0, 1); send(32'h81, 8);
    cs_drive(0, 1'b1);
    vectors++; if (we_n_a - w0 !== 1) begin miscompares++; $display("FAIL mr_next_count got %0d exp 1", we_n_a - w0); end
    vectors++; if (we_addr_a !== 7'h0A) begin miscompares++; $display("FAIL mr_next_addr got %h exp 0a", we_addr_a); end
    vectors++; if (we_data_a !== 8'h81) begin miscompares++; $display("FAIL mr_next_data got %h exp 81", we_data_a); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_burst_wrap;
    test_no_burst;
    test_abort;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
